// File: rtl/aud_recorder_if.sv
// rtl/aud_recorder_if.sv - SRAM write bus from the recorder to memory and the playback DSP
interface aud_recorder_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] o_address;
    logic [DATA_W-1:0] o_data;
    logic              o_we;
    logic [ADDR_W-1:0] o_last_addr;

    modport master (
        output o_address,
        output o_data,
        output o_we,
        output o_last_addr
    );

    modport slave (
        input o_address,
        input o_data,
        input o_we,
        input o_last_addr
    );
endinterface

// File: rtl/aud_recorder.sv
// rtl/aud_recorder.sv - I2S ADC left-channel capture into consecutive SRAM words
module aud_recorder #(
    parameter int                ADDR_W   = 20,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_lrc,
    input  logic           i_data,
    input  logic           i_start,
    input  logic           i_pause,
    input  logic           i_stop,
    aud_recorder_if.master wr,
    output logic           o_recording,
    output logic           o_done
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_L,
        S_SHIFT,
        S_STORE,
        S_PAUSE
    } state_t;

    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    state_t            r_state;
    logic              r_lrc_d;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_address;
    logic [DATA_W-1:0] r_data;
    logic              r_we;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_recording;
    logic              r_done;

    state_t w_next;
    logic   w_lrc_fall;
    logic   w_shift_en;
    logic   w_cnt_clr;
    logic   w_done;
    logic   w_new_rec;
    logic   w_capture;

    assign w_lrc_fall = r_lrc_d & ~i_lrc;

    always_comb begin
        w_next     = r_state;
        w_shift_en = 1'b0;
        w_cnt_clr  = 1'b0;
        w_done     = 1'b0;
        w_new_rec  = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // stop wins over start here and produces no done pulse
                if (!i_stop && i_start) begin
                    w_next    = S_WAIT_L;
                    w_new_rec = 1'b1;
                end
            end
            S_WAIT_L: begin
                if (i_stop) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end else if (i_pause) begin
                    w_next = S_PAUSE;
                end else if (w_lrc_fall) begin
                    w_next    = S_SHIFT;
                    w_cnt_clr = 1'b1;
                end
            end
            S_SHIFT: begin
                if (i_stop) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end else if (i_pause) begin
                    w_next = S_PAUSE;
                end else if (r_cnt == CNT_FULL) begin
                    w_next    = S_STORE;
                    w_capture = 1'b1;
                end else begin
                    w_shift_en = 1'b1;
                end
            end
            S_STORE: begin
                if (r_address == MAX_ADDR) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end else begin
                    w_next = S_WAIT_L;
                end
            end
            S_PAUSE: begin
                if (i_stop) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end else if (!i_pause && i_start) begin
                    w_next = S_WAIT_L;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_lrc_d     <= 1'b0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_address   <= '0;
            r_data      <= '0;
            r_we        <= 1'b0;
            r_last_addr <= '0;
            r_recording <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_lrc_d     <= i_lrc;
            r_done      <= w_done;
            r_we        <= w_capture;
            r_recording <= (w_next == S_WAIT_L) || (w_next == S_SHIFT) || (w_next == S_STORE);

            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_shift_en) begin
                r_cnt   <= r_cnt + 1'b1;
                r_shift <= {r_shift[DATA_W-2:0], i_data};
            end

            // o_data is loaded as STORE is entered so it is stable for the whole strobe cycle
            if (w_capture) begin
                r_data <= r_shift;
            end

            if (w_new_rec) begin
                r_address   <= '0;
                r_last_addr <= '0;
            end else if (r_state == S_STORE) begin
                r_last_addr <= r_address;
                if (w_next == S_WAIT_L) begin
                    r_address <= r_address + 1'b1;
                end
            end
        end
    end

    assign wr.o_address   = r_address;
    assign wr.o_data      = r_data;
    assign wr.o_we        = r_we;
    assign wr.o_last_addr = r_last_addr;
    assign o_recording    = r_recording;
    assign o_done         = r_done;
endmodule

// File: tb/tb_aud_recorder.sv
// tb/tb_aud_recorder.sv - randomized I2S stimulus against a write-log reference model
module tb_aud_recorder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lrc = 1'b1;
    logic sdata = 1'b0;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic stop = 1'b0;
    logic rec_a, done_a, rec_b, done_b;

    always #5 clk = ~clk;

    aud_recorder_if #(.ADDR_W(20), .DATA_W(16)) bus_a ();
    aud_recorder_if #(.ADDR_W(20), .DATA_W(16)) bus_b ();

    aud_recorder #(.ADDR_W(20), .DATA_W(16)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_lrc(lrc), .i_data(sdata),
        .i_start(start), .i_pause(pause), .i_stop(stop),
        .wr(bus_a), .o_recording(rec_a), .o_done(done_a)
    );

    aud_recorder #(.ADDR_W(20), .DATA_W(16), .MAX_ADDR(20'd3)) u_full (
        .i_clk(clk), .i_rst(rst), .i_lrc(lrc), .i_data(sdata),
        .i_start(start), .i_pause(pause), .i_stop(stop),
        .wr(bus_b), .o_recording(rec_b), .o_done(done_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // observed write log and pulse statistics, per instance
    logic [35:0] act_q [2][$];
    int          we_long [2] = '{0, 0};
    int          done_cnt [2] = '{0, 0};
    int          done_long [2] = '{0, 0};
    logic        prev_we [2] = '{1'b0, 1'b0};
    logic        prev_done [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        if (bus_a.o_we) act_q[0].push_back({bus_a.o_address, bus_a.o_data});
        if (bus_b.o_we) act_q[1].push_back({bus_b.o_address, bus_b.o_data});
        if (bus_a.o_we && prev_we[0]) we_long[0] <= we_long[0] + 1;
        if (bus_b.o_we && prev_we[1]) we_long[1] <= we_long[1] + 1;
        if (done_a) done_cnt[0] <= done_cnt[0] + 1;
        if (done_b) done_cnt[1] <= done_cnt[1] + 1;
        if (done_a && prev_done[0]) done_long[0] <= done_long[0] + 1;
        if (done_b && prev_done[1]) done_long[1] <= done_long[1] + 1;
        prev_we[0]   <= bus_a.o_we;
        prev_we[1]   <= bus_b.o_we;
        prev_done[0] <= done_a;
        prev_done[1] <= done_b;
    end

    // reference model: recording session semantics, not cycle behaviour
    int          m_addr [2] = '{0, 0};
    int          m_last [2] = '{0, 0};
    int          m_done [2] = '{0, 0};
    bit          m_rec [2] = '{1'b0, 1'b0};
    bit          m_paused [2] = '{1'b0, 1'b0};
    int          m_max [2] = '{20'hFFFFF, 3};
    logic [35:0] exp_q [2][$];

    task automatic model_start();
        for (int i = 0; i < 2; i++) begin
            if (m_paused[i]) begin
                m_paused[i] = 1'b0;
                m_rec[i]    = 1'b1;
            end else if (!m_rec[i]) begin
                m_rec[i]  = 1'b1;
                m_addr[i] = 0;
                m_last[i] = 0;
            end
        end
    endtask

    task automatic model_pause();
        for (int i = 0; i < 2; i++)
            if (m_rec[i]) begin
                m_rec[i]    = 1'b0;
                m_paused[i] = 1'b1;
            end
    endtask

    task automatic model_stop();
        for (int i = 0; i < 2; i++)
            if (m_rec[i] || m_paused[i]) begin
                m_done[i]++;
                m_rec[i]    = 1'b0;
                m_paused[i] = 1'b0;
            end
    endtask

    task automatic model_frame(input logic [15:0] w);
        for (int i = 0; i < 2; i++)
            if (m_rec[i]) begin
                exp_q[i].push_back({20'(m_addr[i]), w});
                m_last[i] = m_addr[i];
                if (m_addr[i] == m_max[i]) begin
                    m_rec[i] = 1'b0;
                    m_done[i]++;
                end else begin
                    m_addr[i]++;
                end
            end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_rec[i]    = 1'b0;
            m_paused[i] = 1'b0;
            m_addr[i]   = 0;
            m_last[i]   = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        model_start();
    endtask

    // act: 0 none, 1 raise pause, 2 one-cycle stop, 3 one-cycle reset; applied at left-half cycle act_k
    task automatic send_frame(input logic [15:0] lw, input logic [15:0] rw,
                              input int half, input int act, input int act_k);
        for (int k = 0; k < half; k++) begin
            lrc   = 1'b0;
            sdata = (k >= 1 && k <= 16) ? lw[16-k] : 1'($urandom);
            if (act == 1 && k == act_k) pause = 1'b1;
            if (act == 2) stop = (k == act_k);
            if (act == 3) rst = (k == act_k);
            step();
        end
        stop = 1'b0;
        rst  = 1'b0;
        for (int k = 0; k < half; k++) begin
            lrc   = 1'b1;
            sdata = (k >= 1 && k <= 16) ? rw[16-k] : 1'($urandom);
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_checks++; if (bus_a.o_address !== 20'd0) begin n_errors++; $display("FAIL reset_addr: got %0h expected 0", bus_a.o_address); end
        n_checks++; if (bus_a.o_data !== 16'd0) begin n_errors++; $display("FAIL reset_data: got %0h expected 0", bus_a.o_data); end
        n_checks++; if (bus_a.o_we !== 1'b0) begin n_errors++; $display("FAIL reset_we: got %0b expected 0", bus_a.o_we); end
        n_checks++; if (bus_a.o_last_addr !== 20'd0) begin n_errors++; $display("FAIL reset_last: got %0h expected 0", bus_a.o_last_addr); end
        n_checks++; if ({rec_a, done_a, rec_b, done_b} !== 4'b0) begin n_errors++; $display("FAIL reset_flags: got %b expected 0000", {rec_a, done_a, rec_b, done_b}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_idle_start_stop();
        start = 1'b1;
        stop  = 1'b1;
        repeat (4) step();
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) step();
        n_checks++; if ({rec_a, rec_b} !== 2'b00) begin n_errors++; $display("FAIL idle_ss_rec: got %b expected 00", {rec_a, rec_b}); end
        n_checks++; if (done_cnt[0] !== m_done[0]) begin n_errors++; $display("FAIL idle_ss_done: got %0d expected %0d", done_cnt[0], m_done[0]); end
        n_checks++; if (act_q[0].size() !== 0) begin n_errors++; $display("FAIL idle_ss_writes: got %0d expected 0", act_q[0].size()); end
    endtask

    task automatic test_basic_frames();
        logic [15:0] words [3] = '{16'h8001, 16'h1234, 16'hFFFF};
        pulse_start();
        for (int f = 0; f < 3; f++) begin
            send_frame(words[f], 16'hAAAA, 32, 0, 0);
            model_frame(words[f]);
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (act_q[i].size() !== exp_q[i].size()) begin n_errors++; $display("FAIL basic_count[%0d]: got %0d expected %0d", i, act_q[i].size(), exp_q[i].size()); end
            for (int j = 0; j < act_q[i].size() && j < exp_q[i].size(); j++) begin
                n_checks++; if (act_q[i][j] !== exp_q[i][j]) begin n_errors++; $display("FAIL basic_write[%0d][%0d]: got %h expected %h", i, j, act_q[i][j], exp_q[i][j]); end
                n_checks++; if (act_q[i][j][15:0] === 16'hAAAA) begin n_errors++; $display("FAIL basic_right_leak[%0d]: got %h expected not aaaa", i, act_q[i][j][15:0]); end
            end
            act_q[i].delete();
            exp_q[i].delete();
        end
        n_checks++; if (bus_a.o_last_addr !== 20'(m_last[0])) begin n_errors++; $display("FAIL basic_last: got %0d expected %0d", bus_a.o_last_addr, m_last[0]); end
        n_checks++; if (we_long[0] !== 0) begin n_errors++; $display("FAIL basic_we_width: got %0d expected 0", we_long[0]); end
        n_checks++; if (rec_a !== 1'b1) begin n_errors++; $display("FAIL basic_rec: got %0b expected 1", rec_a); end
    endtask

    task automatic test_pause();
        send_frame(16'h0F0F, 16'hAAAA, 32, 1, 9);
        model_pause();
        n_checks++; if (rec_a !== 1'b0) begin n_errors++; $display("FAIL pause_rec: got %0b expected 0", rec_a); end
        send_frame(16'h7777, 16'hAAAA, 24, 0, 0);
        pause = 1'b0;
        pulse_start();
        send_frame(16'h5A5A, 16'hAAAA, 20, 0, 0);
        model_frame(16'h5A5A);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (act_q[i].size() !== exp_q[i].size()) begin n_errors++; $display("FAIL pause_count[%0d]: got %0d expected %0d", i, act_q[i].size(), exp_q[i].size()); end
            for (int j = 0; j < act_q[i].size() && j < exp_q[i].size(); j++) begin
                n_checks++; if (act_q[i][j] !== exp_q[i][j]) begin n_errors++; $display("FAIL pause_write[%0d][%0d]: got %h expected %h", i, j, act_q[i][j], exp_q[i][j]); end
            end
            n_checks++; if (done_cnt[i] !== m_done[i]) begin n_errors++; $display("FAIL pause_done[%0d]: got %0d expected %0d", i, done_cnt[i], m_done[i]); end
            act_q[i].delete();
            exp_q[i].delete();
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 6; f++) begin
            logic [15:0] w;
            w = 16'($urandom);
            send_frame(w, 16'($urandom), int'($urandom_range(24, 18)), 0, 0);
            model_frame(w);
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (act_q[i].size() !== exp_q[i].size()) begin n_errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, act_q[i].size(), exp_q[i].size()); end
            for (int j = 0; j < act_q[i].size() && j < exp_q[i].size(); j++) begin
                n_checks++; if (act_q[i][j] !== exp_q[i][j]) begin n_errors++; $display("FAIL rand_write[%0d][%0d]: got %h expected %h", i, j, act_q[i][j], exp_q[i][j]); end
            end
            act_q[i].delete();
            exp_q[i].delete();
        end
        n_checks++; if (bus_a.o_last_addr !== 20'(m_last[0])) begin n_errors++; $display("FAIL rand_last: got %0d expected %0d", bus_a.o_last_addr, m_last[0]); end
        n_checks++; if (we_long[0] !== 0 || we_long[1] !== 0) begin n_errors++; $display("FAIL rand_we_width: got %0d/%0d expected 0/0", we_long[0], we_long[1]); end
    endtask

    task automatic test_stop();
        int last_before;
        last_before = m_last[0];
        send_frame(16'hC3C3, 16'hAAAA, 28, 2, 9);
        model_stop();
        n_checks++; if (act_q[0].size() !== 0) begin n_errors++; $display("FAIL stop_nowrite: got %0d expected 0", act_q[0].size()); end
        n_checks++; if (done_cnt[0] !== m_done[0] || done_long[0] !== 0) begin n_errors++; $display("FAIL stop_done: got %0d/%0d expected %0d/0", done_cnt[0], done_long[0], m_done[0]); end
        n_checks++; if (bus_a.o_last_addr !== 20'(last_before)) begin n_errors++; $display("FAIL stop_last: got %0d expected %0d", bus_a.o_last_addr, last_before); end
        n_checks++; if (rec_a !== 1'b0) begin n_errors++; $display("FAIL stop_rec: got %0b expected 0", rec_a); end
        pulse_start();
        n_checks++; if (bus_a.o_address !== 20'd0) begin n_errors++; $display("FAIL stop_restart_addr: got %0d expected 0", bus_a.o_address); end
        send_frame(16'h2468, 16'hAAAA, 20, 0, 0);
        model_frame(16'h2468);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (act_q[i].size() !== exp_q[i].size()) begin n_errors++; $display("FAIL stop_count[%0d]: got %0d expected %0d", i, act_q[i].size(), exp_q[i].size()); end
            for (int j = 0; j < act_q[i].size() && j < exp_q[i].size(); j++) begin
                n_checks++; if (act_q[i][j] !== exp_q[i][j]) begin n_errors++; $display("FAIL stop_write[%0d][%0d]: got %h expected %h", i, j, act_q[i][j], exp_q[i][j]); end
            end
            act_q[i].delete();
            exp_q[i].delete();
        end
    endtask

    task automatic test_full_memory();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        step();
        pulse_start();
        for (int f = 0; f < 5; f++) begin
            logic [15:0] w;
            w = 16'($urandom);
            send_frame(w, 16'hAAAA, int'($urandom_range(22, 18)), 0, 0);
            model_frame(w);
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (act_q[i].size() !== exp_q[i].size()) begin n_errors++; $display("FAIL full_count[%0d]: got %0d expected %0d", i, act_q[i].size(), exp_q[i].size()); end
            for (int j = 0; j < act_q[i].size() && j < exp_q[i].size(); j++) begin
                n_checks++; if (act_q[i][j] !== exp_q[i][j]) begin n_errors++; $display("FAIL full_write[%0d][%0d]: got %h expected %h", i, j, act_q[i][j], exp_q[i][j]); end
            end
            act_q[i].delete();
            exp_q[i].delete();
        end
        n_checks++; if (bus_b.o_last_addr !== 20'(m_last[1])) begin n_errors++; $display("FAIL full_last: got %0d expected %0d", bus_b.o_last_addr, m_last[1]); end
        n_checks++; if (bus_b.o_address !== 20'(m_addr[1])) begin n_errors++; $display("FAIL full_nowrap: got %0d expected %0d", bus_b.o_address, m_addr[1]); end
        n_checks++; if (done_cnt[1] !== m_done[1] || done_long[1] !== 0) begin n_errors++; $display("FAIL full_done: got %0d/%0d expected %0d/0", done_cnt[1], done_long[1], m_done[1]); end
        n_checks++; if (rec_b !== 1'b0) begin n_errors++; $display("FAIL full_rec: got %0b expected 0", rec_b); end
    endtask

    task automatic test_reset_in_store();
        logic [15:0] w;
        w = 16'($urandom);
        send_frame(w, 16'hAAAA, 20, 3, 18);
        model_frame(w);
        model_reset();
        send_frame(16'h9999, 16'hAAAA, 20, 0, 0);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (act_q[i].size() !== exp_q[i].size()) begin n_errors++; $display("FAIL rst_store_count[%0d]: got %0d expected %0d", i, act_q[i].size(), exp_q[i].size()); end
            for (int j = 0; j < act_q[i].size() && j < exp_q[i].size(); j++) begin
                n_checks++; if (act_q[i][j] !== exp_q[i][j]) begin n_errors++; $display("FAIL rst_store_write[%0d][%0d]: got %h expected %h", i, j, act_q[i][j], exp_q[i][j]); end
            end
            act_q[i].delete();
            exp_q[i].delete();
        end
        n_checks++; if (we_long[0] !== 0) begin n_errors++; $display("FAIL rst_store_we: got %0d expected 0", we_long[0]); end
        n_checks++; if ({bus_a.o_address, bus_a.o_data, bus_a.o_last_addr} !== 56'd0) begin n_errors++; $display("FAIL rst_store_outs: got %h expected 0", {bus_a.o_address, bus_a.o_data, bus_a.o_last_addr}); end
        n_checks++; if ({bus_a.o_we, rec_a, done_a} !== 3'b0) begin n_errors++; $display("FAIL rst_store_flags: got %b expected 000", {bus_a.o_we, rec_a, done_a}); end
    endtask

    initial begin
        step();
        test_reset();
        test_idle_start_stop();
        test_basic_frames();
        test_pause();
        test_random_frames();
        test_stop();
        test_full_memory();
        test_reset_in_store();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
